// File: rtl/nibble_rx_pkg.sv
// Shared types and frame constants for the nibble serial receiver.
package nibble_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int   FRAME_BITS = 6;
  localparam int   DATA_BITS  = 4;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/nibble_serial_rx_sync_ff.sv
// Multi-stage single-bit synchroniser; resets to the idle (high) line level.
module sync_ff
  import nibble_rx_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the async input through the flop chain
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= {STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/nibble_serial_rx.sv
// Deserialises start/4-data/stop frames from an async line into a parallel nibble
// with one-clock valid and framing-error strobes.
module nibble_serial_rx
  import nibble_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_serial,
  output logic [3:0] number,
  output logic       number_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] HALF_M1  = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_M1  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] number_q, number_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (rx_serial),
    .q_o     (rxs)
  );

  // State, counters, shift register and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      number_q  <= 4'h0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      number_q  <= number_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; tick counter restarts on every state entry
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + TICK_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    number_d  = number_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (rxs != IDLE_LEVEL) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (tick_q == HALF_M1) begin
          tick_d = '0;
          if (rxs == IDLE_LEVEL) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (tick_q == FULL_M1) begin
          tick_d             = '0;
          shift_d[bit_idx_q] = rxs;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_STOP: begin
        if (tick_q == FULL_M1) begin
          tick_d = '0;
          if (rxs == IDLE_LEVEL) begin
            number_d = shift_q;
            valid_d  = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end else begin
          state_d = ST_STOP;
        end
      end

      // Hold here so a stuck-low line cannot look like a fresh start bit
      ST_WAIT_IDLE: begin
        tick_d = '0;
        if (rxs == IDLE_LEVEL) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end

      default: begin
        tick_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign number       = number_q;
  assign number_valid = valid_q;
  assign frame_error  = ferr_q;
  assign busy         = busy_q;

endmodule
